// File: rtl/aes_key_sched_128.sv
// AES-128 key expansion: one round key per clock, streamed out and kept in an
// 11-entry round-key file for the inverse cipher.
module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] d
);
    localparam logic [2047:0] TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };
    // Entry 0 sits in the top byte, so index from the top down.
    assign d = TABLE[{~a, 3'b000} +: 8];
endmodule

module aes_key_sched_128 (
    input  logic         clk,
    input  logic         rst,
    input  logic         kld,
    input  logic [127:0] key,
    output logic         busy,
    output logic         done,
    output logic         rk_valid,
    output logic [3:0]   rk_round,
    output logic [127:0] rk_out,
    input  logic [3:0]   rd_idx,
    output logic [127:0] rd_key
);
    typedef enum logic {IDLE, EXPAND} state_t;

    state_t         state_q, state_d;
    logic [127:0]   w_q, w_d;
    logic [7:0]     rcon_q, rcon_d;
    logic [3:0]     rnd_q, rnd_d;
    logic           busy_q, busy_d, done_q, done_d, rkv_q, rkv_d;
    logic [3:0]     rkr_q, rkr_d;
    logic [127:0]   rko_q, rko_d;
    logic [127:0]   rdk_q;
    logic [127:0]   file_q [0:10];
    logic           wr_en;
    logic [3:0]     wr_idx;
    logic [127:0]   wr_data;
    logic [31:0]    rot, sub, t, n0, n1, n2, n3;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // SubWord(RotWord(w3)); w3 is the least significant word of w_q.
    assign rot = {w_q[23:0], w_q[31:24]};
    for (genvar i = 0; i < 4; i++) begin : g_sbox
        aes_sbox u_sbox (.a(rot[8*i +: 8]), .d(sub[8*i +: 8]));
    end

    assign t  = sub ^ {rcon_q, 24'h0};
    assign n0 = w_q[127:96] ^ t;
    assign n1 = w_q[95:64]  ^ n0;
    assign n2 = w_q[63:32]  ^ n1;
    assign n3 = w_q[31:0]   ^ n2;

    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        rcon_d  = rcon_q;
        rnd_d   = rnd_q;
        busy_d  = busy_q;
        done_d  = done_q;
        rkv_d   = 1'b0;
        rkr_d   = rkr_q;
        rko_d   = rko_q;
        wr_en   = 1'b0;
        wr_idx  = rnd_q;
        wr_data = {n0, n1, n2, n3};
        if (kld) begin
            state_d = EXPAND;
            w_d     = key;
            rcon_d  = 8'h01;
            rnd_d   = 4'd1;
            busy_d  = 1'b1;
            done_d  = 1'b0;
            rkv_d   = 1'b1;
            rkr_d   = 4'd0;
            rko_d   = key;
            wr_en   = 1'b1;
            wr_idx  = 4'd0;
            wr_data = key;
        end else if (state_q == EXPAND) begin
            w_d    = {n0, n1, n2, n3};
            rcon_d = xtime(rcon_q);
            rnd_d  = rnd_q + 4'd1;
            rkv_d  = 1'b1;
            rkr_d  = rnd_q;
            rko_d  = {n0, n1, n2, n3};
            wr_en  = 1'b1;
            if (rnd_q == 4'd10) begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            w_q     <= '0;
            rcon_q  <= 8'h01;
            rnd_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rkv_q   <= 1'b0;
            rkr_q   <= '0;
            rko_q   <= '0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            rcon_q  <= rcon_d;
            rnd_q   <= rnd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            rkv_q   <= rkv_d;
            rkr_q   <= rkr_d;
            rko_q   <= rko_d;
        end
    end

    // Read and write share an edge, so a same-index read returns pre-write data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 11; i++) file_q[i] <= '0;
            rdk_q <= '0;
        end else begin
            if (wr_en) file_q[wr_idx] <= wr_data;
            rdk_q <= (rd_idx <= 4'd10) ? file_q[rd_idx] : '0;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign rk_valid = rkv_q;
    assign rk_round = rkr_q;
    assign rk_out   = rko_q;
    assign rd_key   = rdk_q;
endmodule

// File: tb/tb_aes_key_sched_128.sv
// Bench for aes_key_sched_128: scoreboard of expected round keys from an
// independent FIPS-197 style expansion model (S-box derived from GF(2^8)).
module tb_aes_key_sched_128;
    logic         clk = 1'b0;
    logic         rst;
    logic         kld;
    logic [127:0] key;
    logic         busy, done, rk_valid;
    logic [3:0]   rk_round;
    logic [127:0] rk_out;
    logic [3:0]   rd_idx;
    logic [127:0] rd_key;

    int total = 0;
    int bad   = 0;

    typedef struct { logic [3:0] rnd; logic [127:0] val; } exp_t;
    exp_t sbq[$];

    localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] ZERO_RK1  = 128'h62636363626363636263636362636363;
    localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
    localparam logic [127:0] KEY_A     = 128'h000102030405060708090a0b0c0d0e0f;

    aes_key_sched_128 dut (
        .clk(clk), .rst(rst), .kld(kld), .key(key),
        .busy(busy), .done(done), .rk_valid(rk_valid),
        .rk_round(rk_round), .rk_out(rk_out),
        .rd_idx(rd_idx), .rd_key(rd_key)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic logic [7:0] m_xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] m_gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = m_xt(a);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] m_rol(input logic [7:0] b, input int n);
        logic [15:0] d;
        d = {b, b} << n;
        return d[15:8];
    endfunction

    function automatic logic [7:0] m_sbox(input logic [7:0] x);
        logic [7:0] inv = 8'h01;
        for (int i = 0; i < 254; i++) inv = m_gmul(inv, x);
        if (x == 8'h00) inv = 8'h00;
        return inv ^ m_rol(inv, 1) ^ m_rol(inv, 2) ^ m_rol(inv, 3) ^ m_rol(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [127:0] model_rk(input logic [127:0] k, input int r);
        logic [31:0] w [0:43];
        logic [31:0] tmp;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {m_sbox(tmp[31:24]), m_sbox(tmp[23:16]), m_sbox(tmp[15:8]), m_sbox(tmp[7:0])};
                tmp = tmp ^ {rc, 24'h0};
                rc  = m_xt(rc);
            end
            w[i] = w[i-4] ^ tmp;
        end
        return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    task automatic test_reset();
        rst = 1'b0; kld = 1'b1; key = FIPS_KEY; rd_idx = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
        total++; if (rk_valid !== 1'b0) begin bad++; $display("FAIL reset_rkv: got %b want 0", rk_valid); end
        total++; if (rk_round !== 4'd0) begin bad++; $display("FAIL reset_rkr: got %0d want 0", rk_round); end
        total++; if (rk_out !== 128'h0) begin bad++; $display("FAIL reset_rko: got %h want 0", rk_out); end
        total++; if (rd_key !== 128'h0) begin bad++; $display("FAIL reset_rdkey: got %h want 0", rd_key); end
        @(negedge clk); kld = 1'b0; rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_expand(input string nm, input logic [127:0] k, input logic [127:0] lit1, input logic [127:0] lit10);
        exp_t e;
        int   pulses = 0;
        for (int r = 0; r < 11; r++) sbq.push_back('{rnd: 4'(r), val: model_rk(k, r)});
        @(negedge clk); kld = 1'b1; key = k;
        for (int c = 0; c < 11; c++) begin
            @(posedge clk); #1;
            if (c == 0) kld = 1'b0;
            if (rk_valid === 1'b1) pulses++;
            total++;
            if (rk_valid !== 1'b1) begin bad++; $display("FAIL %s_rkv c%0d: got %b want 1", nm, c, rk_valid); end
            else if (sbq.size() == 0) begin bad++; $display("FAIL %s_sb c%0d: output with empty scoreboard", nm, c); end
            else begin
                e = sbq.pop_front();
                total++; if (rk_round !== e.rnd) begin bad++; $display("FAIL %s_round c%0d: got %0d want %0d", nm, c, rk_round, e.rnd); end
                total++; if (rk_out !== e.val) begin bad++; $display("FAIL %s_key r%0d: got %h want %h", nm, e.rnd, rk_out, e.val); end
            end
            if (c == 1) begin total++; if (rk_out !== lit1) begin bad++; $display("FAIL %s_rk1: got %h want %h", nm, rk_out, lit1); end end
            if (c == 10) begin total++; if (rk_out !== lit10) begin bad++; $display("FAIL %s_rk10: got %h want %h", nm, rk_out, lit10); end end
            total++; if (busy !== (c < 10)) begin bad++; $display("FAIL %s_busy c%0d: got %b want %b", nm, c, busy, c < 10); end
            total++; if (done !== (c == 10)) begin bad++; $display("FAIL %s_done c%0d: got %b want %b", nm, c, done, c == 10); end
        end
        @(posedge clk); #1;
        if (rk_valid === 1'b1) pulses++;
        total++; if (pulses !== 11) begin bad++; $display("FAIL %s_pulses: got %0d want 11", nm, pulses); end
        total++; if (rk_round !== 4'd10 || rk_out !== lit10) begin bad++; $display("FAIL %s_hold: got %0d/%h want 10/%h", nm, rk_round, rk_out, lit10); end
        total++; if (done !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL %s_idle: got done=%b busy=%b want 1/0", nm, done, busy); end
    endtask

    task automatic test_readback(input string nm, input logic [127:0] k);
        logic [127:0] want;
        for (int i = 0; i < 16; i++) begin
            int idx = (i <= 10) ? 10 - i : i;
            @(negedge clk); rd_idx = 4'(idx);
            @(posedge clk); #1;
            want = (idx <= 10) ? model_rk(k, idx) : 128'h0;
            total++; if (rd_key !== want) begin bad++; $display("FAIL %s_rd%0d: got %h want %h", nm, idx, rd_key, want); end
        end
    endtask

    task automatic test_restart();
        exp_t e;
        for (int r = 0; r < 4; r++) sbq.push_back('{rnd: 4'(r), val: model_rk(KEY_A, r)});
        for (int r = 0; r < 11; r++) sbq.push_back('{rnd: 4'(r), val: model_rk(FIPS_KEY, r)});
        @(negedge clk); kld = 1'b1; key = KEY_A;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk); #1;
            if (c == 0 || c == 4) kld = 1'b0;
            total++;
            if (rk_valid !== 1'b1) begin bad++; $display("FAIL restart_rkv c%0d: got %b want 1", c, rk_valid); end
            else if (sbq.size() == 0) begin bad++; $display("FAIL restart_sb c%0d: output with empty scoreboard", c); end
            else begin
                e = sbq.pop_front();
                total++; if (rk_round !== e.rnd || rk_out !== e.val) begin bad++; $display("FAIL restart_key c%0d: got %0d/%h want %0d/%h", c, rk_round, rk_out, e.rnd, e.val); end
            end
            total++; if (done !== (c == 14)) begin bad++; $display("FAIL restart_done c%0d: got %b want %b", c, done, c == 14); end
            if (c == 3) begin kld = 1'b1; key = FIPS_KEY; end
        end
        total++; if (rk_out !== FIPS_RK10) begin bad++; $display("FAIL restart_rk10: got %h want %h", rk_out, FIPS_RK10); end
        test_readback("restart", FIPS_KEY);
    endtask

    task automatic test_async_reset();
        exp_t e;
        rd_idx = 4'd0;
        for (int r = 0; r < 11; r++) sbq.push_back('{rnd: 4'(r), val: model_rk(FIPS_KEY, r)});
        @(negedge clk); kld = 1'b1; key = FIPS_KEY;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (c == 0) kld = 1'b0;
            total++;
            if (rk_valid !== 1'b1 || sbq.size() == 0) begin bad++; $display("FAIL arst_rkv c%0d: got %b want 1", c, rk_valid); end
            else begin
                e = sbq.pop_front();
                total++; if (rk_out !== e.val) begin bad++; $display("FAIL arst_key c%0d: got %h want %h", c, rk_out, e.val); end
            end
        end
        total++; if (busy !== 1'b1 || rd_key !== FIPS_KEY) begin bad++; $display("FAIL arst_pre: got busy=%b rd=%h want 1/%h", busy, rd_key, FIPS_KEY); end
        #2; rst = 1'b0;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL arst_busy: got %b want 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL arst_done: got %b want 0", done); end
        total++; if (rk_valid !== 1'b0) begin bad++; $display("FAIL arst_rkv: got %b want 0", rk_valid); end
        total++; if (rd_key !== 128'h0) begin bad++; $display("FAIL arst_rdkey: got %h want 0", rd_key); end
        sbq.delete();
        @(negedge clk); rst = 1'b1;
        test_expand("post_rst", FIPS_KEY, FIPS_RK1, FIPS_RK10);
    endtask

    task automatic test_hazard(input logic [127:0] old_k, input logic [127:0] new_k);
        exp_t e;
        logic [127:0] old3, new3;
        old3 = model_rk(old_k, 3);
        new3 = model_rk(new_k, 3);
        rd_idx = 4'd3;
        for (int r = 0; r < 11; r++) sbq.push_back('{rnd: 4'(r), val: model_rk(new_k, r)});
        @(negedge clk); kld = 1'b1; key = new_k;
        for (int c = 0; c < 11; c++) begin
            @(posedge clk); #1;
            if (c == 0) kld = 1'b0;
            total++;
            if (rk_valid !== 1'b1 || sbq.size() == 0) begin bad++; $display("FAIL hazard_rkv c%0d: got %b want 1", c, rk_valid); end
            else begin
                e = sbq.pop_front();
                total++; if (rk_out !== e.val) begin bad++; $display("FAIL hazard_key c%0d: got %h want %h", c, rk_out, e.val); end
            end
            if (c == 3) begin total++; if (rd_key !== old3) begin bad++; $display("FAIL hazard_old: got %h want %h", rd_key, old3); end end
            if (c == 4) begin total++; if (rd_key !== new3) begin bad++; $display("FAIL hazard_new: got %h want %h", rd_key, new3); end end
        end
    endtask

    initial begin
        test_reset();
        test_expand("fips", FIPS_KEY, FIPS_RK1, FIPS_RK10);
        test_readback("fips", FIPS_KEY);
        test_expand("zero", 128'h0, ZERO_RK1, ZERO_RK10);
        test_readback("zero", 128'h0);
        test_restart();
        test_async_reset();
        test_hazard(FIPS_KEY, 128'h0);
        total++; if (sbq.size() != 0) begin bad++; $display("FAIL sb_leftover: got %0d want 0", sbq.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/aes_key_sched_128.md
# aes_key_sched_128

AES-128 key schedule engine that sits directly downstream of the round-constant generator function: it loads a 128-bit cipher key and expands it iteratively into the 11 round keys, one per clock. Each key is streamed to the cipher datapath as it is produced and is also stored in an internal 11-entry round-key file. The file serves the inverse cipher, which consumes keys in reverse order (10 down to 0).

## Interface
Parameters: none (AES-128 only).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- kld  in  1  key-load strobe, single cycle; restarts expansion from any state.
- key  in  128  cipher key; byte 0 is key[127:120]; sampled only when kld=1.
- busy  out  1  expansion in progress.
- done  out  1  all 11 round keys valid; sticky until next kld or reset.
- rk_valid  out  1  one-cycle strobe: rk_out/rk_round carry a new round key.
- rk_round  out  4  index 0..10 of rk_out.
- rk_out  out  128  streamed round key, words w[4r]..w[4r+3] MSW first.
- rd_idx  in  4  round-key file read index.
- rd_key  out  128  round-key file read data, registered.

## Operation
- S-box: four instances of the team's combinational aes_sbox (8-bit a -> 8-bit d) apply SubWord(RotWord(w3)).
- State: w0..w3 (32 b each), rcon (8 b), rnd counter (4 b), 11x128 key file, busy, done.
- States: IDLE (busy=0), EXPAND (busy=1).
  - IDLE -> EXPAND on kld.
  - EXPAND -> IDLE after round 10 is written.
  - kld in EXPAND restarts from round 0.
- kld edge (any state):
  - {w0..w3} <= key; file[0] <= key; rcon <= 8'h01; rnd <= 1.
  - busy <= 1, done <= 0.
  - rk_valid <= 1, rk_round <= 0, rk_out <= key.
- EXPAND edge without kld:
  - t = SubWord(RotWord(w3)) ^ {rcon, 24'h0}
  - n0 = w0^t; n1 = w1^n0; n2 = w2^n1; n3 = w3^n2.
  - {w0..w3} <= {n0..n3}; file[rnd] <= {n0..n3}.
  - rk_valid <= 1, rk_round <= rnd, rk_out <= {n0..n3}.
  - rcon <= xtime(rcon): rcon<<1, XOR 8'h1b if rcon[7] was set (sequence 01,02,04,...,80,1b,36).
  - rnd <= rnd+1.
  - When rnd==10: busy <= 0, done <= 1, next state IDLE.
- IDLE without kld: all state holds; rk_valid=0; rk_out/rk_round hold their last values.
- Read port: rd_key <= (rd_idx<=10) ? file[rd_idx] : 128'h0 every edge, independent of state.
  - Same-edge read and write of one index returns the pre-write contents.
  - Entries not yet written in the current expansion return stale data; consumers gate on done.
- Reset (rst=0, asynchronous): w*, file, rk_out, rd_key = 0; rcon = 8'h01; rnd, rk_round = 0; busy, done, rk_valid = 0; state IDLE. Reset mid-expansion aborts it; rst dominates kld.

## Timing
- kld sampled at edge T: round key 0 appears on rk_out after edge T. Round key k appears after edge T+k (k=1..10).
- busy=1 after edges T..T+9; busy=0 and done=1 after edge T+10. Expansion takes 11 cycles including the load.
- rk_valid is high for exactly 11 consecutive cycles per uninterrupted expansion.
- kld at T+j (j<=10) restarts: the next outputs are round 0 of the new key, and done stays 0.
- rd_key latency: one cycle from rd_idx.
- Critical path: w3 -> sbox -> XOR chain of four 32-bit words -> register.

## Test plan
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, kld at T -> rk_round=1 a0fafe1788542cb123a339392a6c7605 after T+1; rk_round=10 d014f9a8c9ee2589e13f0cc8b6630ca6 after T+10; done=1, busy=0 after T+10; 11 rk_valid pulses.
- Zero key -> rk1 = 62636363626363636263636362636363; rk10 = b4ef5bcb3e92e21123e951cf6f8f188e.
- Reverse readback: after done, sweep rd_idx 10..0 -> rd_key matches the streamed keys with 1-cycle latency; rd_idx=11..15 -> 0.
- Restart: kld with key A, then kld with the FIPS key at T+4 -> done stays 0; the FIPS rk10 appears 10 cycles after the second kld; file[0..10] are all FIPS keys.
- Async reset: rst low mid-cycle at T+5 -> busy, done, rk_valid, rd_key drop to 0 immediately without a clock edge; a subsequent kld expands correctly.
- Same-edge hazard: rd_idx=3 held across edge T+3 of an expansion following a previous key -> rd_key after T+3 shows the old key's rk3; after T+4 it shows the new rk3.
